softmax_normalizer: RTL and testbench

- Downstream consumer of the 8-bit LUT exponential stage.
- Collects one vector of exp codes, accumulates their sum, then emits each element normalised as floor(exp·2^SZ / sum), saturated to SZ bits. Together these complete the softmax path.
- Buffered, valid/ready on both sides; one bit-serial divide per element.

---
 rtl/softmax_pkg.sv | 11 +
 rtl/seq_divider.sv | 79 +++++++
 rtl/softmax_normalizer.sv | 134 +++++++++++++
 tb/tb_softmax_normalizer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and sizing for the softmax normalisation path.
package softmax_pkg;
  localparam int SZ    = 8;
  localparam int N_MAX = 16;
  localparam int ACC_W = SZ + $clog2(N_MAX);
  localparam int IDX_W = $clog2(N_MAX);
  localparam int CNT_W = $clog2(N_MAX + 1);
  localparam logic [SZ-1:0] PROB_MAX = {SZ{1'b1}};

  typedef enum logic [1:0] {ACCUM, DIV, EMIT} state_e;
endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. The upper NUM_W-QW bits of
// the numerator seed the partial remainder, so the quotient must fit in QW
// bits (true for softmax, where each element never exceeds the sum).
module seq_divider #(
  parameter int NUM_W = 16,
  parameter int DEN_W = 12,
  parameter int QW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [QW-1:0]    quo_o,
  output logic             div_by_zero_o
);
  localparam int CW = $clog2(QW + 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             dbz_q;
  logic [QW-1:0]    quo_q;
  logic [QW-1:0]    nsh_q;
  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;

  logic [DEN_W:0] shifted_d;
  logic [DEN_W:0] diff_d;
  logic           ge_d;

  // Trial subtraction for the current quotient bit
  always_comb begin
    shifted_d = {rem_q, nsh_q[QW-1]};
    ge_d      = shifted_d >= {1'b0, den_q};
    diff_d    = shifted_d - {1'b0, den_q};
  end

  // Iteration counter and one-cycle done pulse after the final bit
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= CW'(QW);
      end else if (busy_q) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // Datapath: load operands on start, then shift/subtract each busy cycle
  always_ff @(posedge clk) begin
    if (start_i) begin
      rem_q <= DEN_W'(num_i >> QW);
      nsh_q <= num_i[QW-1:0];
      den_q <= den_i;
      dbz_q <= (den_i == '0);
      quo_q <= '0;
    end else if (busy_q) begin
      rem_q <= ge_d ? diff_d[DEN_W-1:0] : shifted_d[DEN_W-1:0];
      quo_q <= {quo_q[QW-2:0], ge_d};
      nsh_q <= nsh_q << 1;
    end
  end

  assign done_o        = done_q;
  assign quo_o         = quo_q;
  assign div_by_zero_o = dbz_q;
endmodule

// File: rtl/softmax_normalizer.sv
// Buffers one vector of exp codes, sums them, then emits each element as
// floor(exp * 2^SZ / sum) saturated to SZ bits, one divide per element.
module softmax_normalizer
  import softmax_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SZ-1:0] in_exp,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SZ-1:0] out_prob,
  output logic          out_last,
  output logic          busy
);
  state_e           state_q;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] idx_q;
  logic             out_valid_q;
  logic [SZ-1:0]    out_prob_q;
  logic             out_last_q;
  logic [SZ-1:0]    mem_q [N_MAX];

  logic             accept;
  logic             last_d;
  logic [ACC_W-1:0] sum_d;
  logic             div_start;
  logic [SZ-1:0]    div_exp_d;
  logic [ACC_W-1:0] div_den_d;
  logic             div_done;
  logic [SZ:0]      div_quo;
  logic             div_dbz;

  function automatic logic [SZ-1:0] sat_prob(input logic [SZ:0] q);
    return q[SZ] ? PROB_MAX : q[SZ-1:0];
  endfunction

  // Input handshake, forced last at buffer capacity, and divider launch.
  // The first element's divide starts on the accepting edge, so its operands
  // bypass the buffer and running sum registers being written that same edge.
  always_comb begin
    accept    = in_valid && (state_q == ACCUM);
    last_d    = in_last || (count_q == CNT_W'(N_MAX - 1));
    sum_d     = sum_q + ACC_W'(in_exp);
    div_start = 1'b0;
    div_exp_d = mem_q[idx_q + IDX_W'(1)];
    div_den_d = sum_q;
    if (accept && last_d) begin
      div_start = 1'b1;
      div_exp_d = (count_q == '0) ? in_exp : mem_q[0];
      div_den_d = sum_d;
    end else if ((state_q == EMIT) && out_ready && !out_last_q) begin
      div_start = 1'b1;
    end
  end

  seq_divider #(
    .NUM_W (2 * SZ),
    .DEN_W (ACC_W),
    .QW    (SZ + 1)
  ) u_div (
    .clk           (clk),
    .rst           (rst),
    .start_i       (div_start),
    .num_i         ({div_exp_d, {SZ{1'b0}}}),
    .den_i         (div_den_d),
    .done_o        (div_done),
    .quo_o         (div_quo),
    .div_by_zero_o (div_dbz)
  );

  // Element buffer; contents are only meaningful below count_q
  always_ff @(posedge clk) begin
    if (accept) mem_q[count_q[IDX_W-1:0]] <= in_exp;
  end

  // Main control FSM with registered output-side signals
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_prob_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            sum_q   <= sum_d;
            count_q <= count_q + CNT_W'(1);
            if (last_d) begin
              state_q <= DIV;
              idx_q   <= '0;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            state_q     <= EMIT;
            out_valid_q <= 1'b1;
            out_prob_q  <= div_dbz ? '0 : sat_prob(div_quo);
            out_last_q  <= (CNT_W'(idx_q) == count_q - CNT_W'(1));
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              sum_q   <= '0;
              count_q <= '0;
              state_q <= ACCUM;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= DIV;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_prob  = out_prob_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ACCUM) || (count_q != '0);
endmodule

// File: tb/tb_softmax_normalizer.sv
// Self-checking bench for softmax_normalizer against a plain arithmetic model.
module tb_softmax_normalizer;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_exp;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_prob;
  logic       out_last;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int vin[$];
  int got_prob[$];
  int got_last[$];
  int got_vcyc[$];
  int hs_cyc[$];
  int last_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  softmax_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prob  (out_prob),
    .out_last  (out_last),
    .busy      (busy)
  );

  function automatic int ref_prob(input int e, input int s);
    int q;
    if (s == 0) return 0;
    q = (e * 256) / s;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int vec_sum();
    int s = 0;
    foreach (vin[i]) s += vin[i];
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input bit use_last);
    for (int i = 0; i < vin.size(); i++) begin
      int k = 0;
      in_valid = 1'b1;
      in_exp   = 8'(vin[i]);
      in_last  = use_last && (i == vin.size() - 1);
      while (!in_ready && k < 200) begin
        step();
        k++;
      end
      step();
      last_acc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_exp   = 8'd0;
  endtask

  task automatic collect(input int n);
    got_prob.delete();
    got_last.delete();
    got_vcyc.delete();
    hs_cyc.delete();
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (!out_valid && k < 200) begin
        step();
        k++;
      end
      if (!out_valid) break;
      got_prob.push_back(int'(out_prob));
      got_last.push_back(int'(out_last));
      got_vcyc.push_back(cyc);
      out_ready = 1'b1;
      step();
      hs_cyc.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_exp = 8'd0; out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_prob !== 8'd0) begin failures++; $display("FAIL reset_out_prob got=%0d exp=0", out_prob); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_equal();
    int s;
    vin = '{64, 64, 64, 64};
    s = vec_sum();
    out_ready = 1'b1;
    drive_vec(1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL equal_busy got=%b exp=1", busy); end
    collect(4);
    checks++; if (got_prob.size() != 4) begin failures++; $display("FAIL equal_count got=%0d exp=4", got_prob.size()); end
    for (int i = 0; i < got_prob.size(); i++) begin
      checks++;
      if (got_prob[i] != ref_prob(vin[i], s) || got_last[i] != int'(i == 3)) begin
        failures++;
        $display("FAIL equal_elem%0d got=%0d/%0d exp=%0d/%0d", i, got_prob[i], got_last[i], ref_prob(vin[i], s), int'(i == 3));
      end
    end
    if (got_vcyc.size() > 0) begin
      checks++;
      if (got_vcyc[0] - last_acc != 10) begin failures++; $display("FAIL equal_latency got=%0d exp=10", got_vcyc[0] - last_acc); end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL equal_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_saturate();
    vin = '{200};
    out_ready = 1'b1;
    drive_vec(1'b1);
    collect(1);
    checks++;
    if (got_prob.size() != 1) begin failures++; $display("FAIL sat_count got=%0d exp=1", got_prob.size()); end
    else if (got_prob[0] != 255 || got_last[0] != 1) begin
      failures++; $display("FAIL sat_value got=%0d/%0d exp=255/1", got_prob[0], got_last[0]);
    end
  endtask

  task automatic test_zero();
    vin = '{0, 0};
    out_ready = 1'b1;
    drive_vec(1'b1);
    collect(2);
    checks++; if (got_prob.size() != 2) begin failures++; $display("FAIL zero_count got=%0d exp=2", got_prob.size()); end
    for (int i = 0; i < got_prob.size(); i++) begin
      checks++;
      if (got_prob[i] != 0 || got_last[i] != int'(i == 1)) begin
        failures++; $display("FAIL zero_elem%0d got=%0d/%0d exp=0/%0d", i, got_prob[i], got_last[i], int'(i == 1));
      end
    end
    if (got_vcyc.size() == 2) begin
      checks++;
      if (got_vcyc[0] - last_acc != 10) begin failures++; $display("FAIL zero_latency got=%0d exp=10", got_vcyc[0] - last_acc); end
      checks++;
      if (got_vcyc[1] - hs_cyc[0] != 10) begin failures++; $display("FAIL zero_spacing got=%0d exp=10", got_vcyc[1] - hs_cyc[0]); end
    end
  endtask

  task automatic test_forced_last();
    vin.delete();
    for (int i = 0; i < 16; i++) vin.push_back(1);
    out_ready = 1'b1;
    drive_vec(1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL forced_in_ready got=%b exp=0", in_ready); end
    // Stray input while dividing must be ignored
    in_valid = 1'b1; in_exp = 8'd99; in_last = 1'b1;
    repeat (3) step();
    in_valid = 1'b0; in_exp = 8'd0; in_last = 1'b0;
    collect(16);
    checks++; if (got_prob.size() != 16) begin failures++; $display("FAIL forced_count got=%0d exp=16", got_prob.size()); end
    for (int i = 0; i < got_prob.size(); i++) begin
      checks++;
      if (got_prob[i] != 16 || got_last[i] != int'(i == 15)) begin
        failures++; $display("FAIL forced_elem%0d got=%0d/%0d exp=16/%0d", i, got_prob[i], got_last[i], int'(i == 15));
      end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL forced_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    vin = '{10, 30};
    out_ready = 1'b0;
    drive_vec(1'b1);
    while (!out_valid && k < 200) begin step(); k++; end
    checks++;
    if (out_valid !== 1'b1 || out_prob !== 8'd64 || out_last !== 1'b0) begin
      failures++; $display("FAIL bp_first got=%b/%0d/%b exp=1/64/0", out_valid, out_prob, out_last);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_prob !== 8'd64 || out_last !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%0d/%b exp=1/64/0", i, out_valid, out_prob, out_last);
      end
    end
    out_ready = 1'b1;
    step();
    collect(1);
    checks++;
    if (got_prob.size() != 1) begin failures++; $display("FAIL bp_count got=%0d exp=1", got_prob.size()); end
    else if (got_prob[0] != 192 || got_last[0] != 1) begin
      failures++; $display("FAIL bp_second got=%0d/%0d exp=192/1", got_prob[0], got_last[0]);
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    vin = '{100, 100, 100};
    out_ready = 1'b0;
    drive_vec(1'b1);
    while (!out_valid && k < 200) begin step(); k++; end
    checks++;
    if (out_valid !== 1'b1 || out_prob !== 8'd85) begin
      failures++; $display("FAIL rstmid_pre got=%b/%0d exp=1/85", out_valid, out_prob);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_prob !== 8'd0) begin
      failures++; $display("FAIL rstmid_post got=%b/%b/%b/%0d exp=0/1/0/0", out_valid, in_ready, busy, out_prob);
    end
    vin = '{128};
    out_ready = 1'b1;
    drive_vec(1'b1);
    collect(1);
    checks++;
    if (got_prob.size() != 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", got_prob.size()); end
    else if (got_prob[0] != 255 || got_last[0] != 1) begin
      failures++; $display("FAIL rstmid_new got=%0d/%0d exp=255/1", got_prob[0], got_last[0]);
    end
  endtask

  task automatic test_random();
    for (int v = 0; v < 8; v++) begin
      int len;
      int s;
      bit use_last;
      len = int'($urandom_range(1, 16));
      use_last = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      vin.delete();
      for (int i = 0; i < len; i++) vin.push_back(int'($urandom_range(0, 255)));
      s = vec_sum();
      out_ready = 1'b1;
      drive_vec(use_last);
      collect(len);
      checks++;
      if (got_prob.size() != len) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", v, got_prob.size(), len); end
      for (int i = 0; i < got_prob.size(); i++) begin
        checks++;
        if (got_prob[i] != ref_prob(vin[i], s) || got_last[i] != int'(i == len - 1)) begin
          failures++;
          $display("FAIL rand%0d_elem%0d got=%0d/%0d exp=%0d/%0d", v, i, got_prob[i], got_last[i], ref_prob(vin[i], s), int'(i == len - 1));
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_equal();
    test_saturate();
    test_zero();
    test_forced_last();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
